// File: rtl/hazard_controller.sv
// hazard_controller: load-use, data-memory-wait and redirect stall/flush sequencer for the 5-stage core.
// Optional stall/flush performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_controller #(
    parameter int IMEM_LAT    = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        D_E_mem_rd,
    input  logic [4:0]  D_E_rd_adr,
    input  logic [4:0]  rs1_adr,
    input  logic [4:0]  rs2_adr,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  logic        branch_taken,
    input  logic        E_M_mem_req,
    input  logic        dmem_ready,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        stall_M,
    output logic        flush_D,
    output logic        bubble_E,
    output logic        mem_err,
    output logic [1:0]  state,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);
    typedef enum logic [1:0] {RUN = 2'b00, MEMWAIT = 2'b01, REDIR = 2'b10} state_t;
    state_t     st_q, st_d;
    logic [9:0] wcnt_q, wcnt_d;
    logic [2:0] sq_q, sq_d;
    logic       lu, mw, to, hold, stall_all, stall_fd, flush, bubble;
    assign lu = D_E_mem_rd && D_E_rd_adr != 5'd0 &&
                ((rs1_used && rs1_adr == D_E_rd_adr) || (rs2_used && rs2_adr == D_E_rd_adr));
    assign mw = E_M_mem_req && !dmem_ready;
    assign to = st_q == MEMWAIT && mw && ({1'b0, wcnt_q} + 11'd1 >= 11'(MEM_TIMEOUT));
    // A timed-out access is abandoned, so its wait no longer holds the pipe.
    assign hold = mw && !to;
    always_comb begin
        st_d      = RUN;
        wcnt_d    = 10'd0;
        sq_d      = sq_q;
        stall_all = 1'b0;
        stall_fd  = 1'b0;
        flush     = 1'b0;
        bubble    = 1'b0;
        if (hold) begin
            st_d      = MEMWAIT;
            wcnt_d    = st_q == MEMWAIT ? wcnt_q + 10'd1 : 10'd1;
            stall_all = 1'b1;
        end else if (branch_taken) begin
            flush  = 1'b1;
            bubble = 1'b1;
            sq_d   = 3'(IMEM_LAT);
            st_d   = IMEM_LAT > 0 ? REDIR : RUN;
        end else if (sq_q != 3'd0) begin
            // Pending squash (possibly interrupted by a memory wait) keeps flushing D.
            flush = 1'b1;
            sq_d  = sq_q - 3'd1;
            st_d  = sq_q == 3'd1 ? RUN : REDIR;
        end else if (lu) begin
            stall_fd = 1'b1;
            bubble   = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= RUN;
            wcnt_q  <= 10'd0;
            sq_q    <= 3'd0;
            mem_err <= 1'b0;
        end else begin
            st_q    <= st_d;
            wcnt_q  <= wcnt_d;
            sq_q    <= sq_d;
            mem_err <= to;
        end
    end
    assign stall_F  = !rst && (stall_all || stall_fd);
    assign stall_D  = !rst && (stall_all || stall_fd);
    assign stall_E  = !rst && stall_all;
    assign stall_M  = !rst && stall_all;
    assign flush_D  = !rst && flush;
    assign bubble_E = !rst && bubble;
    assign state    = st_q;
`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (stall_F && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
            if (flush_D && !(&flush_cnt)) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed-vector bench for hazard_controller (IMEM_LAT=2, MEM_TIMEOUT=4).
module tb_hazard_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        D_E_mem_rd, rs1_used, rs2_used, branch_taken, E_M_mem_req, dmem_ready;
    logic [4:0]  D_E_rd_adr, rs1_adr, rs2_adr;
    logic        stall_F, stall_D, stall_E, stall_M, flush_D, bubble_E, mem_err;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;
    logic [5:0]  hz;
    int          n_chk = 0, n_fail = 0;
    int          exp_sc = 0, exp_fc = 0;

    hazard_controller #(.IMEM_LAT(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .D_E_mem_rd(D_E_mem_rd), .D_E_rd_adr(D_E_rd_adr),
        .rs1_adr(rs1_adr), .rs2_adr(rs2_adr), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .branch_taken(branch_taken), .E_M_mem_req(E_M_mem_req), .dmem_ready(dmem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .bubble_E(bubble_E), .mem_err(mem_err), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;
    assign hz = {stall_F, stall_D, stall_E, stall_M, flush_D, bubble_E};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic ld, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic br, input logic req, input logic rdy);
        D_E_mem_rd = ld; D_E_rd_adr = rd; rs1_adr = r1; rs2_adr = r2;
        rs1_used = u1; rs2_used = u2; branch_taken = br; E_M_mem_req = req; dmem_ready = rdy;
    endtask

    // hz order: stall_F stall_D stall_E stall_M flush_D bubble_E
    task automatic vec(input string tag, input logic [5:0] e_hz, input logic [1:0] e_st, input logic e_me);
        #2;
        chk({tag, ".hz"}, 32'(hz), 32'(e_hz));
        chk({tag, ".st"}, 32'(state), 32'(e_st));
        chk({tag, ".err"}, 32'(mem_err), 32'(e_me));
        if (e_hz[5]) exp_sc++;
        if (e_hz[1]) exp_fc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drv(1, 5, 0, 5, 0, 1, 0, 0, 0);
        #2;
        chk("rst.hz", 32'(hz), 32'd0);
        chk("rst.st", 32'(state), 32'd0);
        chk("rst.err", 32'(mem_err), 32'd0);
        chk("rst.scnt", stall_cnt, 32'd0);
        chk("rst.fcnt", flush_cnt, 32'd0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drv(1, 5, 0, 5, 0, 1, 0, 0, 0); vec("lu_rs2", 6'b110001, 2'd0, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); vec("lu_done", 6'b000000, 2'd0, 1'b0);
        drv(1, 0, 0, 0, 0, 1, 0, 0, 0); vec("lu_x0", 6'b000000, 2'd0, 1'b0);
        drv(1, 5, 0, 5, 0, 0, 0, 0, 0); vec("lu_unused", 6'b000000, 2'd0, 1'b0);
        drv(1, 7, 7, 3, 1, 0, 0, 0, 0); vec("lu_rs1", 6'b110001, 2'd0, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0); vec("mw1", 6'b111100, 2'd0, 1'b0);
        vec("mw2", 6'b111100, 2'd1, 1'b0);
        vec("mw3", 6'b111100, 2'd1, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1); vec("mw_rdy", 6'b000000, 2'd1, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); vec("mw_run", 6'b000000, 2'd0, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0); vec("to1", 6'b111100, 2'd0, 1'b0);
        vec("to2", 6'b111100, 2'd1, 1'b0);
        vec("to3", 6'b111100, 2'd1, 1'b0);
        vec("to4", 6'b000000, 2'd1, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); vec("to_err", 6'b000000, 2'd0, 1'b1);
        vec("to_after", 6'b000000, 2'd0, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0); vec("br0", 6'b000011, 2'd0, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); vec("br1", 6'b000010, 2'd2, 1'b0);
        vec("br2", 6'b000010, 2'd2, 1'b0);
        vec("br3", 6'b000000, 2'd0, 1'b0);
        drv(1, 5, 0, 5, 0, 1, 1, 0, 0); vec("brlu0", 6'b000011, 2'd0, 1'b0);
        drv(1, 5, 0, 5, 0, 1, 0, 0, 0); vec("brlu1", 6'b000010, 2'd2, 1'b0);
        vec("brlu2", 6'b000010, 2'd2, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); vec("brlu3", 6'b000000, 2'd0, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 1, 1, 0); vec("mwbr0", 6'b111100, 2'd0, 1'b0);
        vec("mwbr1", 6'b111100, 2'd1, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 1, 1, 1); vec("mwbr_rdy", 6'b000011, 2'd1, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); vec("mwbr3", 6'b000010, 2'd2, 1'b0);
        vec("mwbr4", 6'b000010, 2'd2, 1'b0);
        vec("mwbr5", 6'b000000, 2'd0, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0); vec("rdmw0", 6'b000011, 2'd0, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0); vec("rdmw1", 6'b111100, 2'd2, 1'b0);
        vec("rdmw2", 6'b111100, 2'd1, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1); vec("rdmw3", 6'b000010, 2'd1, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); vec("rdmw4", 6'b000010, 2'd2, 1'b0);
        vec("rdmw5", 6'b000000, 2'd0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        chk("scnt", stall_cnt, 32'(exp_sc));
        chk("fcnt", flush_cnt, 32'(exp_fc));
`else
        chk("scnt_off", stall_cnt, 32'd0);
        chk("fcnt_off", flush_cnt, 32'd0);
`endif
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0); vec("rrd0", 6'b000011, 2'd0, 1'b0);
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
        #2;
        chk("rrd.pre", 32'(state), 32'd2);
        rst = 1'b1;
        #1;
        chk("rrd.hz", 32'(hz), 32'd0);
        chk("rrd.st", 32'(state), 32'd0);
        chk("rrd.err", 32'(mem_err), 32'd0);
        chk("rrd.scnt", stall_cnt, 32'd0);
        chk("rrd.fcnt", flush_cnt, 32'd0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        vec("rrd_run", 6'b000000, 2'd0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
